if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage that feeds the decode stage. It owns the fetch PC and issues requests to a synchronous-read instruction memory with one-cycle latency. It presents {pc, inst, valid} to decode, and accepts redirects from decode (taken branch or jump target) and stall requests from the hazard logic. A hold buffer preserves the returned instruction while decode is stalled.

Parameters:
PC_WIDTH, 32, width of PC and instruction-memory address.
INST_WIDTH, 32, instruction width.
RESET_PC, 32'h4000_0000, first fetch address after reset.
NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) presented when the output is not valid.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
stall  in  1  hold the fetch PC and the decode-facing outputs.
ctrl_pc_src  in  1  redirect request from decode.
branch_pc_new  in  PC_WIDTH  redirect target from decode.
ctrl_id_reg_flush  in  1  kill the fetch currently in flight.
imem_en  out  1  instruction-memory read enable.
imem_addr  out  PC_WIDTH  instruction-memory read address, byte address.
imem_rdata  in  INST_WIDTH  read data, valid on the cycle after imem_en.
if_pc  out  PC_WIDTH  PC of the instruction presented to decode.
if_inst  out  INST_WIDTH  instruction presented to decode.
if_valid  out  1  if_inst is a real, non-killed instruction.

Behaviour:
- State registers:
  - pc_f: address being requested.
  - resp_pc / resp_valid: the request issued in the previous cycle.
  - hold_inst / hold_valid: skid buffer.
  - fs: 2-bit FSM with states BOOT, RUN, HOLD.
- Reset (rst=0, asynchronous):
  - pc_f=RESET_PC, resp_pc=RESET_PC, resp_valid=0, hold_valid=0, hold_inst=NOP_INST, fs=BOOT.
  - Outputs: imem_en=0, if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC.
- Combinational outputs:
  - imem_addr=pc_f.
  - imem_en = (fs!=BOOT) & ~stall, or redirect (redirect forces a new fetch).
  - if_pc=resp_pc.
  - if_inst = hold_valid ? hold_inst : imem_rdata, forced to NOP_INST when if_valid=0.
  - if_valid = resp_valid.
- kill = ctrl_pc_src | ctrl_id_reg_flush.
- Priority each cycle: reset > redirect (ctrl_pc_src) > flush > stall > normal advance.
- BOOT: lasts exactly one cycle after reset release and issues no fetch. It then goes to RUN with pc_f unchanged, so the first fetch of RESET_PC occurs in the first RUN cycle and its instruction appears at decode one cycle later.
- RUN, no stall, no kill:
  - imem_en=1.
  - resp_pc<=pc_f, resp_valid<=1.
  - pc_f<=pc_f+4, wrapping modulo 2^PC_WIDTH.
  - Steady-state throughput is one instruction per cycle.
- Redirect (ctrl_pc_src=1, any state except reset):
  - pc_f<=branch_pc_new with bits [1:0] forced to 0.
  - resp_valid<=0, hold_valid<=0, fs<=RUN.
  - The wrong-path fetch issued this cycle returns next cycle with if_valid=0.
  - stall is ignored in that cycle.
- Flush without redirect (ctrl_id_reg_flush=1, ctrl_pc_src=0):
  - Same as normal advance, except resp_valid<=0.
  - The next cycle shows a bubble; the fetch stream continues sequentially.
- Stall from RUN:
  - pc_f, resp_pc and resp_valid are held; imem_en=0.
  - If hold_valid=0, capture hold_inst<=imem_rdata and set hold_valid<=1. fs<=HOLD.
- HOLD, stall still high: all state frozen, outputs unchanged every cycle.
- HOLD, stall low:
  - Decode consumes the held instruction this cycle.
  - Normal advance occurs: imem_en=1, resp_pc<=pc_f, resp_valid<=1.
  - hold_valid<=0, fs<=RUN.
- Output invariant: while stall=1, if_pc, if_inst and if_valid must not change between consecutive cycles, even though the memory output is unstable.
- Reset asserted mid-stall or mid-redirect returns to the reset values immediately, without waiting for a clock edge.
- Total fetch-to-decode latency is 1 cycle.

Decomposition:
- Shared package, also used by decode and hazard: the fetch FSM state encoding (BOOT/RUN/HOLD), the NOP_INST constant, RESET_PC, and the PC increment constant 4.
- One sub-module: if_skid_buffer. It holds hold_inst/hold_valid and performs the output mux, with inputs capture, clear and rdata.
- PC register and FSM stay in if_stage.

Test Plan:
- Reset then free-run, memory returning inst = address>>2:
  - Cycle after reset release: imem_en=0.
  - Next cycle: imem_addr=0x4000_0000.
  - Decode then sees pc 0x4000_0000, 0x4000_0004, 0x4000_0008 with valid=1 on consecutive cycles.
- Redirect: at decode pc 0x4000_0008, pulse ctrl_pc_src=1 with target 0x4000_0103.
  - Next cycle: if_valid=0 with if_inst=NOP_INST, then if_pc=0x4000_0100, valid=1.
- Stall: hold stall=1 for 3 cycles while pc 0x4000_0004 is presented, driving random imem_rdata.
  - if_pc, if_inst and if_valid stay constant.
  - After release, 0x4000_0008 follows with no gap and no duplicate.
- Simultaneous stall=1 and ctrl_pc_src=1 with target 0x4000_0200:
  - Redirect wins: a bubble, then 0x4000_0200 valid.
  - The hold buffer is cleared.
- Flush only: ctrl_id_reg_flush=1 for one cycle.
  - Exactly one bubble (if_valid=0) appears.
  - The sequential PC resumes without skipping any address.
- Wrap: RESET_PC=32'hFFFF_FFFC.
  - Second fetch address is 0x0000_0000.
  - Assert rst low mid-stall: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Fetch-stage shared definitions: FSM encoding, reset PC, NOP and PC step.
// Also used by the decode and hazard units.
package if_stage_pkg;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] IF_RESET_PC = 32'h4000_0000;
    localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;
    localparam int unsigned IF_PC_INC   = 4;

endpackage

// File: rtl/if_skid_buffer.sv
// Holds the returned instruction while decode is stalled and muxes
// the decode-facing instruction between the buffer and memory.
module if_skid_buffer
    import if_stage_pkg::*;
#(
    parameter int unsigned             INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0]   NOP_INST   = INST_WIDTH'(IF_NOP_INST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [INST_WIDTH-1:0] rdata,
    output logic [INST_WIDTH-1:0] inst
);

    logic                  hold_valid;
    logic [INST_WIDTH-1:0] hold_inst;

    // First stalled cycle latches memory; later ones keep the copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_inst  <= NOP_INST;
        end else if (clear) begin
            hold_valid <= 1'b0;
        end else if (capture && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_inst  <= rdata;
        end
    end

    assign inst = !valid     ? NOP_INST  :
                  hold_valid ? hold_inst : rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, drives a 1-cycle synchronous
// instruction memory and presents {pc, inst, valid} to decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned           PC_WIDTH   = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(IF_RESET_PC),
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(IF_NOP_INST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  ctrl_pc_src,
    input  logic [PC_WIDTH-1:0]   branch_pc_new,
    input  logic                  ctrl_id_reg_flush,
    output logic                  imem_en,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]   if_pc,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic                  if_valid
);

    fetch_state_e        fs;
    logic [PC_WIDTH-1:0] pc_f;
    logic [PC_WIDTH-1:0] resp_pc;
    logic                resp_valid;

    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] pc_tgt;
    logic                kill;
    logic                running;
    logic                do_redir;
    logic                do_boot;
    logic                do_flush;
    logic                do_stall;
    logic                do_adv;
    logic                skid_clear;
    logic                unused_tgt_lsb;

    assign pc_next = pc_f + PC_WIDTH'(IF_PC_INC);
    assign pc_tgt  = {branch_pc_new[PC_WIDTH-1:2], 2'b00};
    assign unused_tgt_lsb = ^branch_pc_new[1:0];

    assign kill    = ctrl_pc_src | ctrl_id_reg_flush;
    assign running = (fs != FS_BOOT);

    // One-hot action decode in priority order.
    assign do_redir = ctrl_pc_src;
    assign do_boot  = ~ctrl_pc_src & ~running;
    assign do_flush = ~ctrl_pc_src & ctrl_id_reg_flush & running;
    assign do_stall = ~kill & stall & running;
    assign do_adv   = ~kill & ~stall & running;

    assign skid_clear = do_redir | do_flush | do_adv;

    assign imem_en   = rst & ((running & ~stall) | ctrl_pc_src);
    assign imem_addr = pc_f;
    assign if_pc     = resp_pc;
    assign if_valid  = resp_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fs         <= FS_BOOT;
            pc_f       <= RESET_PC;
            resp_pc    <= RESET_PC;
            resp_valid <= 1'b0;
        end else begin
            unique case (1'b1)
                do_redir: begin
                    pc_f       <= pc_tgt;
                    resp_pc    <= pc_f;
                    resp_valid <= 1'b0;
                    fs         <= FS_RUN;
                end
                do_boot: begin
                    fs <= FS_RUN;
                end
                do_flush: begin
                    pc_f       <= pc_next;
                    resp_pc    <= pc_f;
                    resp_valid <= 1'b0;
                    fs         <= FS_RUN;
                end
                do_stall: begin
                    fs <= FS_HOLD;
                end
                do_adv: begin
                    pc_f       <= pc_next;
                    resp_pc    <= pc_f;
                    resp_valid <= 1'b1;
                    fs         <= FS_RUN;
                end
                default: begin
                    fs <= fs;
                end
            endcase
        end
    end

    if_skid_buffer #(
        .INST_WIDTH (INST_WIDTH),
        .NOP_INST   (NOP_INST)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .capture (do_stall),
        .clear   (skid_clear),
        .valid   (resp_valid),
        .rdata   (imem_rdata),
        .inst    (if_inst)
    );

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a transaction-level fetch model,
// plus directed redirect/stall/flush and PC-wrap/async-reset scenarios.
module tb_if_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h4000_0000;
    localparam logic [31:0] WRPC  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        ctrl_pc_src = 1'b0;
    logic [31:0] branch_pc_new = '0;
    logic        ctrl_id_reg_flush = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    logic        w_rst = 1'b0;
    logic        w_stall = 1'b0;
    logic        w_zero = 1'b0;
    logic [31:0] w_tgt = '0;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_rdata = '0;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic        w_valid;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: next address to fetch and the instruction decode sees.
    logic        m_boot;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a >> 2;
    endfunction

    // Sync-read memory; garbage when not enabled so stale data is visible.
    always @(posedge clk) imem_rdata <= imem_en ? memf(imem_addr) : $urandom;
    always @(posedge clk) w_rdata    <= w_en    ? memf(w_addr)    : $urandom;

    if_stage u_dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .ctrl_pc_src       (ctrl_pc_src),
        .branch_pc_new     (branch_pc_new),
        .ctrl_id_reg_flush (ctrl_id_reg_flush),
        .imem_en           (imem_en),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .if_pc             (if_pc),
        .if_inst           (if_inst),
        .if_valid          (if_valid)
    );

    if_stage #(.RESET_PC(WRPC)) u_wrap (
        .clk               (clk),
        .rst               (w_rst),
        .stall             (w_stall),
        .ctrl_pc_src       (w_zero),
        .branch_pc_new     (w_tgt),
        .ctrl_id_reg_flush (w_zero),
        .imem_en           (w_en),
        .imem_addr         (w_addr),
        .imem_rdata        (w_rdata),
        .if_pc             (w_pc),
        .if_inst           (w_inst),
        .if_valid          (w_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One cycle: drive, check against the model, clock, advance the model.
    task automatic step(input logic s, input logic src,
                        input logic [31:0] tgt, input logic fl);
        logic exp_en;
        stall             = s;
        ctrl_pc_src       = src;
        branch_pc_new     = tgt;
        ctrl_id_reg_flush = fl;
        #1;
        exp_en = (!m_boot && !s) || src;
        chk("imem_en", 32'(imem_en), 32'(exp_en));
        chk("imem_addr", imem_addr, m_fetch);
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        if (m_valid) begin
            chk("if_pc", if_pc, m_pc);
            chk("if_inst", if_inst, memf(m_pc));
        end else begin
            chk("if_nop", if_inst, NOP);
        end
        @(posedge clk);
        if (src) begin
            m_valid = 1'b0;
            m_fetch = tgt & 32'hFFFF_FFFC;
        end else if (m_boot) begin
            m_valid = 1'b0;
        end else if (fl) begin
            m_valid = 1'b0;
            m_fetch = m_fetch + 32'd4;
        end else if (!s) begin
            m_pc    = m_fetch;
            m_valid = 1'b1;
            m_fetch = m_fetch + 32'd4;
        end
        m_boot = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic see(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(if_valid), 32'd1);
        chk({tag, "_pc"}, if_pc, pc);
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_en", 32'(imem_en), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_inst", if_inst, NOP);
        chk("rst_pc", if_pc, RPC);

        m_boot  = 1'b1;
        m_valid = 1'b0;
        m_pc    = RPC;
        m_fetch = RPC;
        rst     = 1'b1;

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        see("first", RPC);
        step(0, 0, 0, 0);
        see("second", RPC + 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            see("stalled", RPC + 32'd4);
            chk("stalled_inst", if_inst, memf(RPC + 32'd4));
        end
        step(0, 0, 0, 0);
        see("after_stall", RPC + 32'd8);

        step(0, 1, 32'h4000_0103, 0);
        chk("redir_bubble", 32'(if_valid), 32'd0);
        chk("redir_nop", if_inst, NOP);
        step(0, 0, 0, 0);
        see("redir_tgt", 32'h4000_0100);

        step(1, 1, 32'h4000_0200, 0);
        chk("sr_bubble", 32'(if_valid), 32'd0);
        chk("sr_hold_clr", 32'(u_dut.u_skid.hold_valid), 32'd0);
        step(0, 0, 0, 0);
        see("sr_tgt", 32'h4000_0200);

        step(0, 0, 0, 1);
        chk("flush_bubble", 32'(if_valid), 32'd0);
        chk("flush_bpc", if_pc, 32'h4000_0204);
        step(0, 0, 0, 0);
        see("flush_resume", 32'h4000_0208);

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 100) < 30, ($urandom % 100) < 6,
                 $urandom, ($urandom % 100) < 6);
        end
        stall = 1'b0;
        ctrl_pc_src = 1'b0;
        ctrl_id_reg_flush = 1'b0;

        // PC wrap and asynchronous reset on the second instance.
        w_rst = 1'b1;
        #1;
        chk("w_boot_en", 32'(w_en), 32'd0);
        @(negedge clk);
        #1;
        chk("w_fetch0_en", 32'(w_en), 32'd1);
        chk("w_fetch0", w_addr, WRPC);
        @(negedge clk);
        #1;
        chk("w_wrap_addr", w_addr, 32'h0000_0000);
        chk("w_valid", 32'(w_valid), 32'd1);
        chk("w_pc", w_pc, WRPC);
        w_stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("w_stall_pc", w_pc, WRPC);
        chk("w_stall_inst", w_inst, memf(WRPC));
        #2;
        w_rst = 1'b0;
        #1;
        chk("w_arst_valid", 32'(w_valid), 32'd0);
        chk("w_arst_pc", w_pc, WRPC);
        chk("w_arst_inst", w_inst, NOP);
        chk("w_arst_en", 32'(w_en), 32'd0);
        chk("w_arst_addr", w_addr, WRPC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
